// File: rtl/norm_rr_scheduler_if.sv
// Requester and result handshake bundle for the shared normalizer.
// The DUT side uses the slave modport; requesters and the consumer use master.
interface norm_rr_scheduler_if #(
    parameter int N_REQ = 4
);
    localparam int TAG_W = $clog2(N_REQ);

    logic [N_REQ-1:0]    req_valid;
    logic [12*N_REQ-1:0] req_res;
    logic [5*N_REQ-1:0]  req_exp;
    logic [N_REQ-1:0]    req_ready;
    logic                out_valid;
    logic                out_ready;
    logic [10:0]         out_man;
    logic [4:0]          out_exp;
    logic                out_ovf;
    logic [TAG_W-1:0]    out_tag;

    modport master (
        output req_valid, req_res, req_exp, out_ready,
        input  req_ready, out_valid, out_man, out_exp,
        input  out_ovf, out_tag
    );

    modport slave (
        input  req_valid, req_res, req_exp, out_ready,
        output req_ready, out_valid, out_man, out_exp,
        output out_ovf, out_tag
    );
endinterface

// File: rtl/norm_rr_scheduler.sv
// Round-robin shared fp16 normalizer for FFT butterfly requesters.
// Two-stage valid/ready pipeline; results carry the requester tag.
module norm_rr_scheduler #(
    parameter int N_REQ = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    norm_rr_scheduler_if.slave   bus,
    output logic                 busy,
    output logic [7:0]           ovf_cnt
);
    localparam int TAG_W = $clog2(N_REQ);

    typedef struct packed {
        logic [10:0] man;
        logic [4:0]  exp;
        logic        ovf;
    } norm_t;

    function automatic norm_t normalize(
        input logic [11:0] res,
        input logic [4:0]  exp
    );
        norm_t       r;
        logic [3:0]  p;
        logic [3:0]  k;
        logic [10:0] sh;
        r  = '0;
        p  = '0;
        k  = '0;
        sh = '0;
        unique case (1'b1)
            (res == 12'd0): begin
                r = '0;
            end
            res[11]: begin
                r.man = res[11:1];
                r.exp = exp + 5'd1;
            end
            default: begin
                for (int i = 0; i <= 10; i++) begin
                    if (res[i]) p = 4'(i);
                end
                k     = 4'd10 - p;
                sh    = res[10:0] << k;
                r.man = sh;
                r.exp = exp - 5'(k);
            end
        endcase
        r.ovf = (res != 12'd0) && (r.exp == 5'h1f);
        return r;
    endfunction

    logic [TAG_W-1:0] rr_ptr;
    logic [TAG_W-1:0] grant_idx;
    logic [TAG_W-1:0] idx;
    logic             grant_hit;
    logic             s1_valid;
    logic [11:0]      s1_res;
    logic [4:0]       s1_exp;
    logic [TAG_W-1:0] s1_tag;
    logic             s2_en;
    logic             s1_load;
    logic             accept;
    norm_t            s1_norm;

    assign s2_en   = !bus.out_valid || bus.out_ready;
    assign s1_load = !s1_valid || s2_en;
    assign accept  = !rst && grant_hit && s1_load;
    assign busy    = s1_valid | bus.out_valid;
    assign s1_norm = normalize(s1_res, s1_exp);

    // First valid requester at or after rr_ptr, wrapping.
    always_comb begin
        grant_hit = 1'b0;
        grant_idx = '0;
        idx       = '0;
        for (int j = 0; j < N_REQ; j++) begin
            idx = rr_ptr + TAG_W'(j);
            if (!grant_hit && bus.req_valid[idx]) begin
                grant_hit = 1'b1;
                grant_idx = idx;
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (accept) bus.req_ready[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid      <= 1'b0;
            s1_res        <= '0;
            s1_exp        <= '0;
            s1_tag        <= '0;
            rr_ptr        <= '0;
            bus.out_valid <= 1'b0;
            bus.out_man   <= '0;
            bus.out_exp   <= '0;
            bus.out_ovf   <= 1'b0;
            bus.out_tag   <= '0;
            ovf_cnt       <= '0;
        end else begin
            if (s1_load) s1_valid <= accept;
            if (accept) begin
                s1_res <= bus.req_res[12*grant_idx +: 12];
                s1_exp <= bus.req_exp[5*grant_idx +: 5];
                s1_tag <= grant_idx;
                rr_ptr <= grant_idx + TAG_W'(1);
            end
            if (s2_en) begin
                bus.out_valid <= s1_valid;
                if (s1_valid) begin
                    bus.out_man <= s1_norm.man;
                    bus.out_exp <= s1_norm.exp;
                    bus.out_ovf <= s1_norm.ovf;
                    bus.out_tag <= s1_tag;
                end
            end
            if (bus.out_valid && bus.out_ready &&
                bus.out_ovf && ovf_cnt != 8'hff) begin
                ovf_cnt <= ovf_cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_norm_rr_scheduler.sv
// Bench for norm_rr_scheduler: queue-based reference model checked
// every cycle, plus directed vectors with literal expectations.
module tb_norm_rr_scheduler;
    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       busy;
    logic [7:0] ovf_cnt;

    norm_rr_scheduler_if #(.N_REQ(N)) bus ();

    norm_rr_scheduler #(.N_REQ(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .busy    (busy),
        .ovf_cnt (ovf_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [10:0] man;
        logic [4:0]  exp;
        logic        ovf;
        int          tag;
        int          acc;
    } item_t;

    // Value-level normalization: scale into [1024, 2048) tracking the exponent.
    function automatic item_t model_norm(int r, int e, int tag);
        item_t it;
        int v;
        int x;
        v = r;
        x = e;
        it.tag = tag;
        it.acc = 0;
        if (v == 0) begin
            it.man = 0;
            it.exp = 0;
            it.ovf = 0;
        end else begin
            while (v >= 2048) begin v = v / 2; x = x + 1; end
            while (v < 1024) begin v = v * 2; x = x - 1; end
            it.man = 11'(v);
            it.exp = 5'(x);
            it.ovf = (it.exp == 5'd31);
        end
        return it;
    endfunction

    item_t q[$];
    int    ptr = 0;
    int    mcnt = 0;
    int    cyc = 0;
    bit    started = 0;
    bit    exp_ov;
    bit    load;
    int    g;
    int    idx;
    logic [N-1:0] exp_rdy;
    item_t it;

    always @(negedge clk) begin
        exp_ov = 0;
        load = 0;
        g = -1;
        for (int j = 0; j < N; j++) begin
            idx = (ptr + j) % N;
            if (g < 0 && bus.req_valid[idx]) g = idx;
        end
        load = !(q.size() == 2 && !bus.out_ready);
        if (started && !rst) begin
            exp_ov = q.size() > 0 && q[0].acc < cyc;
            chk("out_valid", bus.out_valid, exp_ov);
            if (exp_ov) begin
                chk("out_man", bus.out_man, q[0].man);
                chk("out_exp", bus.out_exp, q[0].exp);
                chk("out_ovf", bus.out_ovf, q[0].ovf);
                chk("out_tag", bus.out_tag, q[0].tag);
            end
            chk("busy", busy, q.size() > 0);
            chk("ovf_cnt", ovf_cnt, mcnt);
            exp_rdy = '0;
            if (g >= 0 && load) exp_rdy[g] = 1'b1;
            chk("req_ready", bus.req_ready, exp_rdy);
            chk("ready_onehot", $onehot0(bus.req_ready), 1);
        end else if (rst) begin
            chk("ready_in_rst", bus.req_ready, 0);
        end
        if (rst) begin
            q.delete();
            ptr = 0;
            mcnt = 0;
            started = 1;
        end else if (started) begin
            if (exp_ov && bus.out_ready) begin
                if (q[0].ovf && mcnt < 255) mcnt++;
                void'(q.pop_front());
            end
            if (g >= 0 && load) begin
                it = model_norm(int'(bus.req_res[12*g +: 12]),
                                int'(bus.req_exp[5*g +: 5]), g);
                it.acc = cyc + 1;
                q.push_back(it);
                ptr = (g + 1) % N;
            end
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic set_slot(int i, logic [11:0] r, logic [4:0] e);
        bus.req_res[12*i +: 12] = r;
        bus.req_exp[5*i +: 5] = e;
    endtask

    task automatic send(int i, logic [11:0] r, logic [4:0] e);
        bit got;
        got = 0;
        set_slot(i, r, e);
        bus.req_valid[i] = 1'b1;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            if (bus.req_ready[i]) got = 1;
        end
        step();
        bus.req_valid[i] = 1'b0;
        if (!got) chk("send_timeout", 0, 1);
    endtask

    task automatic expect_out(string name, logic [10:0] man,
                              logic [4:0] e, logic ovf, int tag);
        bit got;
        got = 0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (bus.out_valid) got = 1;
        end
        if (!got) begin
            chk({name, "_timeout"}, 0, 1);
        end else begin
            chk({name, "_man"}, bus.out_man, man);
            chk({name, "_exp"}, bus.out_exp, e);
            chk({name, "_ovf"}, bus.out_ovf, ovf);
            chk({name, "_tag"}, bus.out_tag, tag);
        end
        step();
    endtask

    task automatic run_cycles(int n, bit upd);
        logic [N-1:0] m;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            m = bus.req_valid & bus.req_ready;
            step();
            if (upd) begin
                for (int i = 0; i < N; i++) begin
                    if (m[i]) set_slot(i, 12'($urandom), 5'($urandom));
                end
            end
        end
    endtask

    int exp_tags[6] = '{0, 1, 2, 3, 0, 1};

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        logic [N-1:0] m;
        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_res = '0;
        bus.req_exp = '0;
        bus.out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_man", bus.out_man, 0);
        chk("rst_out_exp", bus.out_exp, 0);
        chk("rst_out_ovf", bus.out_ovf, 0);
        chk("rst_out_tag", bus.out_tag, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf_cnt", ovf_cnt, 0);

        send(0, 12'h400, 5'd15);
        expect_out("t1", 11'h400, 5'd15, 1'b0, 0);
        send(2, 12'h800, 5'd30);
        expect_out("t2", 11'h400, 5'd31, 1'b1, 2);
        chk("t2_ovf_cnt", ovf_cnt, 1);
        send(1, 12'h001, 5'd12);
        expect_out("t3a", 11'h400, 5'd2, 1'b0, 1);
        send(1, 12'h000, 5'd7);
        expect_out("t3b", 11'h000, 5'd0, 1'b0, 1);
        send(3, 12'hfff, 5'd31);
        expect_out("wrap_up", 11'h7ff, 5'd0, 1'b0, 3);
        send(0, 12'h3ff, 5'd0);
        expect_out("wrap_dn", 11'h7fe, 5'd31, 1'b1, 0);
        send(2, 12'h055, 5'd5);
        expect_out("shift4", 11'h550, 5'd1, 1'b0, 2);

        do_reset();
        for (int i = 0; i < N; i++) set_slot(i, 12'(12'h0a0 + i), 5'(i + 3));
        bus.req_valid = '1;
        got = 0;
        for (int c = 0; c < 12 && got < 6; c++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                chk("t4_tag", bus.out_tag, exp_tags[got]);
                got++;
            end
            m = bus.req_valid & bus.req_ready;
            step();
            for (int i = 0; i < N; i++) begin
                if (m[i]) set_slot(i, 12'($urandom), 5'($urandom));
            end
        end
        chk("t4_count", got, 6);

        bus.out_ready = 1'b0;
        run_cycles(5, 1);
        @(negedge clk);
        chk("t5_ready_stall", bus.req_ready, 0);
        chk("t5_valid_stall", bus.out_valid, 1);
        chk("t5_busy_stall", busy, 1);
        step();
        bus.out_ready = 1'b1;
        run_cycles(10, 1);
        bus.req_valid = '0;
        run_cycles(4, 0);
        chk("t5_drained", busy, 0);

        bus.req_valid = '1;
        bus.out_ready = 1'b0;
        run_cycles(4, 1);
        chk("t6_full", busy, 1);
        do_reset();
        chk("t6_out_valid", bus.out_valid, 0);
        chk("t6_busy", busy, 0);
        chk("t6_ovf_cnt", ovf_cnt, 0);
        @(negedge clk);
        chk("t6_restart", bus.req_ready, 4'b0001);
        step();
        bus.req_valid = '0;
        bus.out_ready = 1'b1;
        run_cycles(3, 0);

        do_reset();
        set_slot(3, 12'h800, 5'd30);
        bus.req_valid = 4'b1000;
        run_cycles(310, 0);
        bus.req_valid = '0;
        run_cycles(4, 0);
        chk("sat_ovf_cnt", ovf_cnt, 255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
